// File: rtl/adder_pkg.sv
// Shared configuration for pipelined_adder: default geometry and slice-width helper.
// The per-stage record type depends on module parameters, so it is declared in the top.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// SW-bit ripple adder slice built from full_adder cells.
module adder_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          cin_i,
  output logic [SW-1:0] sum_o,
  output logic          cout_o
);

  genvar i;
  generate
    // Per-bit carry nets keep the chain free of self-referencing vectors.
    for (i = 0; i < SW; i++) begin : g_bit
      logic cin;
      logic cout;
      if (i == 0) begin : g_lsb
        assign cin = cin_i;
      end else begin : g_chain
        assign cin = g_bit[i-1].cout;
      end
      full_adder u_fa (
        .a_i   (a_i[i]),
        .b_i   (b_i[i]),
        .cin_i (cin),
        .sum_o (sum_o[i]),
        .cout_o(cout)
      );
    end
  endgenerate

  assign cout_o = g_bit[SW-1].cout;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: STAGES ripple slices with registered inter-slice carry.
// Define ADDER_OVF_EN to build the signed-overflow output; otherwise o_ovf is 0.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned SW = slice_width(WIDTH, STAGES);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif
  } stage_t;

  stage_t in_rec;
  stage_t stage_d [STAGES];
  stage_t stage_q [STAGES];
  logic   adv;

  generate
    if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end
  endgenerate

  function automatic stage_t next_stage(input stage_t          src,
                                        input logic [SW-1:0]   s,
                                        input logic            co,
                                        input int unsigned     k);
    next_stage = src;
    next_stage.sum[k*SW +: SW] = s;
    next_stage.carry = co;
`ifdef ADDER_OVF_EN
    if (k == STAGES - 1)
      next_stage.ovf = (src.a[WIDTH-1] == src.b[WIDTH-1]) & (s[SW-1] != src.a[WIDTH-1]);
`endif
  endfunction

  // Subtraction is A + ~B + 1: invert B here, inject the +1 as stage-0 carry-in.
  always_comb begin
    in_rec       = '0;
    in_rec.valid = i_valid;
    in_rec.carry = i_sub;
    in_rec.a     = i_a;
    in_rec.b     = i_b ^ {WIDTH{i_sub}};
  end

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      stage_t        src;
      logic [SW-1:0] slice_sum;
      logic          slice_cout;

      if (k == 0) begin : g_first
        assign src = in_rec;
      end else begin : g_next
        assign src = stage_q[k-1];
      end

      adder_slice #(.SW(SW)) u_slice (
        .a_i   (src.a[k*SW +: SW]),
        .b_i   (src.b[k*SW +: SW]),
        .cin_i (src.carry),
        .sum_o (slice_sum),
        .cout_o(slice_cout)
      );

      assign stage_d[k] = next_stage(src, slice_sum, slice_cout, k);
    end
  endgenerate

  // One global enable: a stall freezes every stage, bubbles included.
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else if (adv) begin
      stage_q <= stage_d;
    end
  end

  assign o_valid = stage_q[STAGES-1].valid;
  assign o_sum   = stage_q[STAGES-1].sum;
  assign o_cout  = stage_q[STAGES-1].carry;
`ifdef ADDER_OVF_EN
  assign o_ovf   = stage_q[STAGES-1].ovf;
`else
  assign o_ovf   = 1'b0;
`endif

  logic unused_last_ab;
  assign unused_last_ab = ^{stage_q[STAGES-1].a, stage_q[STAGES-1].b};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed vectors, stall, mid-flight reset, depth variants.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  localparam vec_t VT [12] = '{
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
    '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0},
    '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0},
    '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
    '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h4B4B_4B4B, 1'b1, 1'b1},
    '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h0000_0001, 32'h8000_0000, 1'b1, 32'h8000_0001, 1'b0, 1'b1}
  };

`ifdef ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_ready, i_sub;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid, o_cout, o_ovf;
  logic [31:0] o_sum;

  logic        v1, v32, rdy_aux;
  logic        or1, ov1, oc1, oo1, or32, ov32, oc32, oo32;
  logic [31:0] os1, os32;

  always #5 i_clk = ~i_clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v1), .o_ready(or1),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(ov1), .i_ready(rdy_aux),
    .o_sum(os1), .o_cout(oc1), .o_ovf(oo1)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(32)) u_s32 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v32), .o_ready(or32),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(ov32), .i_ready(rdy_aux),
    .o_sum(os32), .o_cout(oc32), .o_ovf(oo32)
  );

  int n_checks = 0;
  int n_err    = 0;
  int exp_q[$];
  int cur_idx  = 0;
  int mon_idx;
  int run_len  = 0;
  int max_run  = 0;

  // Input side: record the hand-computed answer for every accepted operation.
  always @(negedge i_clk) begin
    if (!i_rst_n) exp_q.delete();
    else if (i_valid && o_ready) exp_q.push_back(cur_idx);
  end

  // Output side: every result transfer must match the oldest outstanding operation.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no output",
                 o_sum, o_cout, o_ovf);
      end else begin
        mon_idx = exp_q.pop_front();
        if ({o_sum, o_cout, o_ovf} !== {VT[mon_idx].s, VT[mon_idx].c, VT[mon_idx].v & OVF_ON}) begin
          n_err++;
          $display("FAIL result_vec%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   mon_idx, o_sum, o_cout, o_ovf, VT[mon_idx].s, VT[mon_idx].c,
                   VT[mon_idx].v & OVF_ON);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input int idx);
    i_valid = 1'b1;
    i_a     = VT[idx].a;
    i_b     = VT[idx].b;
    i_sub   = VT[idx].sub;
    cur_idx = idx;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  int lat, lat1, lat32;
  logic [31:0] s1_cap, s32_cap;
  logic        f1_cap, f32_cap;

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_sub = 1'b0;
    i_a = '0; i_b = '0; v1 = 1'b0; v32 = 1'b0; rdy_aux = 1'b1;
    repeat (2) tick();
    i_rst_n = 1'b1;

    @(negedge i_clk);
    check("reset_valid", o_valid, 0);
    check("reset_sum",   o_sum,   0);
    check("reset_cout",  o_cout,  0);
    check("reset_ovf",   o_ovf,   0);
    check("reset_ready", o_ready, 1);
    tick();

    // Back-to-back stream of eight operations.
    max_run = 0;
    for (int i = 0; i < 8; i++) send(i);
    i_valid = 1'b0;
    drain();
    check("stream_consecutive", max_run, 8);

    // Latency of a lone operation through an empty four-stage pipe.
    send(0);
    i_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge i_clk);
      if (o_valid) lat = c;
    end
    check("latency_4", lat, 4);
    drain();

    // Three-cycle back-pressure with the first result at the output.
    for (int i = 8; i < 12; i++) send(i);
    i_valid = 1'b0;
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("stall_ready", o_ready, 0);
      check("stall_valid", o_valid, 1);
      check("stall_sum",   o_sum,   32'h4B4B_4B4B);
      tick();
    end
    i_ready = 1'b1;
    drain();

    // Reset with three operations in flight.
    send(4); send(5); send(6);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("flush_valid", o_valid, 0);
    check("flush_ready", o_ready, 1);
    repeat (8) tick();
    check("flush_queue", exp_q.size(), 0);
    send(9);
    i_valid = 1'b0;
    drain();

    // Single-stage and fully bit-serial pipelines.
    i_a = 32'h7FFF_FFFF; i_b = 32'h0000_0001; i_sub = 1'b0;
    v1 = 1'b1; v32 = 1'b1;
    tick();
    v1 = 1'b0; v32 = 1'b0;
    lat1 = 0; lat32 = 0;
    s1_cap = '0; s32_cap = '0; f1_cap = 1'b0; f32_cap = 1'b0;
    for (int c = 1; c <= 60 && lat32 == 0; c++) begin
      @(negedge i_clk);
      if (lat1 == 0 && ov1) begin lat1 = c; s1_cap = os1; f1_cap = oo1; end
      if (lat32 == 0 && ov32) begin lat32 = c; s32_cap = os32; f32_cap = oo32; end
    end
    check("latency_1",  lat1,    1);
    check("sum_s1",     s1_cap,  32'h8000_0000);
    check("ovf_s1",     f1_cap,  OVF_ON);
    check("latency_32", lat32,   32);
    check("sum_s32",    s32_cap, 32'h8000_0000);
    check("ovf_s32",    f32_cap, OVF_ON);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit; generalised successor of the fixed 32-bit ripple adder. Splits a WIDTH-bit operation into STAGES ripple slices, registering the slice carry between stages, so the carry chain per cycle is WIDTH/STAGES bits long. Carries a valid/ready handshake with back-pressure. Sits between operand-forwarding muxes and writeback wherever a multi-cycle ALU path is acceptable (address generation, multi-cycle EX option).

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and slice count; 1 ≤ STAGES ≤ WIDTH.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  operands valid.
- o_ready  out  1  unit can accept this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_sub  in  1  1 = A − B, 0 = A + B.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_sum  out  WIDTH  result, mod 2^WIDTH.
- o_cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- o_ovf  out  1  signed overflow (see Configuration).

## Operation
- Slice width SW = WIDTH/STAGES. Stage k computes bits [k·SW +: SW] using the carry registered by stage k−1; stage 0 uses carry-in = i_sub.
- Effective B = i_b XOR {WIDTH{i_sub}}; inversion applied at input, before stage 0.
- Each stage register holds: valid bit, computed low sum bits so far, carry out of its slice, and the still-unprocessed upper slices of A and effective B (plus sign bits of A/B for overflow).
- Global advance enable: adv = ~o_valid | i_ready. When adv = 1 every stage register loads from its predecessor (stage 0 from inputs, valid = i_valid). When adv = 0 all stage registers hold.
- o_ready = adv. A transfer in occurs when i_valid & o_ready; a transfer out when o_valid & i_ready.
- Bubbles are not collapsed; stall freezes the whole pipe.
- Outputs o_sum/o_cout/o_ovf come directly from the last stage register; stable while o_valid & ~i_ready.
- Reset: all stage valid bits 0; o_valid = 0, o_sum = 0, o_cout = 0, o_ovf = 0; o_ready = 1 in the first cycle after reset. Reset mid-operation discards all in-flight operations.

## Timing
- Latency: operation accepted at edge N appears with o_valid = 1 in the cycle after edge N+STAGES−1 (STAGES cycles), absent stalls.
- Throughput: one operation per cycle while i_ready = 1.
- Each stall cycle (o_valid & ~i_ready) adds exactly one cycle to every in-flight operation.
- o_ready is combinational from o_valid and i_ready only; no combinational path from i_valid to o_ready.
- STAGES = 1: single-cycle registered full-width ripple adder, latency 1.

## Configuration
- ADDER_OVF_EN defined: o_ovf = (A[MSB] == Beff[MSB]) & (o_sum[MSB] != A[MSB]), registered with the result; sign bits travel down the pipe.
- Not defined: o_ovf tied to 0; sign-bit pipeline registers not built. Sum/carry behaviour identical in both builds.

## Structure
- Package adder_pkg: typedef for the per-stage register record (valid, partial sum, carry, sign bits) built from WIDTH/STAGES, and a function/constant computing SW.
- One sub-module: adder_slice (SW-bit ripple adder with cin/cout, built from the existing full_adder cell), instantiated STAGES times in a generate loop.

## Test plan
- WIDTH=32, STAGES=4, i_ready=1: add 0xFFFF_FFFF + 0x0000_0001 → after 4 cycles o_sum=0, o_cout=1, o_ovf=0.
- Subtract 0x0000_0005 − 0x0000_0007 → o_sum=0xFFFF_FFFE, o_cout=0; 0x8000_0000 − 1 → o_sum=0x7FFF_FFFF, o_ovf=1 (with ADDER_OVF_EN).
- Back-to-back stream of 8 random ops with i_ready=1 → 8 consecutive o_valid cycles, results in order, matching reference model.
- Hold i_ready=0 for 3 cycles while valid result present → o_ready=0, o_sum stable, no op lost or duplicated after release.
- Assert i_rst_n=0 for one cycle with 3 ops in flight → o_valid=0 next cycle, no stale result emerges; o_ready=1.
- STAGES=1 and STAGES=32 builds: 0x7FFF_FFFF + 1 → o_sum=0x8000_0000, o_ovf=1, latency 1 and 32 respectively.
